setpoint_ctrl: RTL

SETPOINT_CTRL -- requirements
Module: setpoint_ctrl

---
 rtl/thermostat_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 72 +++++++
 rtl/setpoint_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/thermostat_pkg.sv
// Shared thermostat FSM state type and default setpoint constants, also used
// by sseg_display users.
package thermostat_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAT = 2'd1,
    COOL = 2'd2
  } therm_state_t;

  localparam int SP_MIN_DEF   = 10;
  localparam int SP_MAX_DEF   = 35;
  localparam int SP_RESET_DEF = 22;
  localparam int HYST_DEF     = 1;

  // Zero-extend so that temperature sums and compares cannot wrap at 255.
  function automatic logic [8:0] widen9(input logic [7:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, level debouncer and one-cycle press pulse for one button.
// Auto-repeat is present only when SETPOINT_AUTOREPEAT_EN is defined.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic            r_level_d;
  logic [DB_W-1:0] r_db_cnt;
  logic            w_rise;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_db_cnt  <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      // Any sample that agrees with the accepted level restarts the count.
      if (r_sync2 == r_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_level  <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  assign w_rise = r_level & ~r_level_d;

`ifdef SETPOINT_AUTOREPEAT_EN
  localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

  logic [RP_W-1:0] r_rep_cnt;
  logic            w_repeat;

  assign w_repeat = r_level & r_level_d & (r_rep_cnt == RP_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rep_cnt <= '0;
    end else if (w_rise || w_repeat || !r_level) begin
      r_rep_cnt <= '0;
    end else begin
      r_rep_cnt <= r_rep_cnt + RP_W'(1);
    end
  end

  assign o_pulse = w_rise | w_repeat;
`else
  assign o_pulse = w_rise;
`endif

endmodule

// File: rtl/setpoint_ctrl.sv
// Thermostat setpoint controller: debounced up/down buttons move the setpoint,
// a hysteretic IDLE/HEAT/COOL FSM drives the heater and cooler. Option: SETPOINT_AUTOREPEAT_EN.
module setpoint_ctrl
  import thermostat_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SP_MIN          = SP_MIN_DEF,
  parameter int SP_MAX          = SP_MAX_DEF,
  parameter int SP_RESET        = SP_RESET_DEF,
  parameter int HYST            = HYST_DEF,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [7:0] CurrentTemp,
  output logic [7:0] ChangedTemp,
  output logic       heat_on,
  output logic       cool_on
);

  localparam logic [7:0] SP_MIN8   = 8'(SP_MIN);
  localparam logic [7:0] SP_MAX8   = 8'(SP_MAX);
  localparam logic [7:0] SP_RESET8 = 8'(SP_RESET);
  localparam logic [8:0] HYST9     = 9'(HYST);

  logic         w_up;
  logic         w_dn;
  logic [7:0]   r_sp;
  logic [8:0]   w_cur9;
  logic [8:0]   w_sp9;
  therm_state_t r_state;
  therm_state_t w_next;
  logic         r_heat;
  logic         r_cool;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_db_up (
    .i_clk  (clk),
    .i_reset(reset),
    .i_btn  (btn_up),
    .o_pulse(w_up)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_db_dn (
    .i_clk  (clk),
    .i_reset(reset),
    .i_btn  (btn_down),
    .o_pulse(w_dn)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp <= SP_RESET8;
    end else if (w_up && !w_dn && (r_sp < SP_MAX8)) begin
      r_sp <= r_sp + 8'd1;
    end else if (w_dn && !w_up && (r_sp > SP_MIN8)) begin
      r_sp <= r_sp - 8'd1;
    end
  end

  assign w_cur9 = widen9(CurrentTemp);
  assign w_sp9  = widen9(r_sp);

  // HEAT and COOL always pass through IDLE, so the outputs never overlap.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_cur9 + HYST9 < w_sp9) begin
          w_next = HEAT;
        end else if (w_cur9 > w_sp9 + HYST9) begin
          w_next = COOL;
        end
      end
      HEAT: if (w_cur9 >= w_sp9) w_next = IDLE;
      COOL: if (w_cur9 <= w_sp9) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_heat  <= 1'b0;
      r_cool  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_heat  <= (w_next == HEAT);
      r_cool  <= (w_next == COOL);
    end
  end

  assign ChangedTemp = r_sp;
  assign heat_on     = r_heat;
  assign cool_on     = r_cool;

endmodule
